alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_shift_step.sv | 32 +++
 rtl/alu_iter.sv | 177 +++++++++++++++++
 tb/tb_alu_iter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared operation encodings and decode helper for the iterative ALU.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1101;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0111;

  typedef struct packed {
    logic is_shift;
    logic left;
    logic arith;
    logic wordable;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [OP_W-1:0] op);
    op_dec_t d;
    d = '{is_shift: 1'b0, left: 1'b0, arith: 1'b0, wordable: 1'b0};
    case (op)
      OP_ADD, OP_SUB: d.wordable = 1'b1;
      OP_SLL: d = '{is_shift: 1'b1, left: 1'b1, arith: 1'b0, wordable: 1'b1};
      OP_SRL: d = '{is_shift: 1'b1, left: 1'b0, arith: 1'b0, wordable: 1'b1};
      OP_SRA: d = '{is_shift: 1'b1, left: 1'b0, arith: 1'b1, wordable: 1'b1};
      default: d.is_shift = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One shifter step: shifts by up to SHIFT_STEP positions in either direction.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 7
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [AW-1:0]   i_amt,
  input  logic            i_left,
  input  logic            i_fill,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] fill_mask_s;

  // Right shifts OR in a mask of vacated positions when the fill bit is set.
  always_comb begin
    fill_mask_s = {XLEN{1'b0}};
    if (i_left) begin
      o_data = i_data << i_amt;
    end else begin
      if (i_fill) begin
        fill_mask_s = ~({XLEN{1'b1}} >> i_amt);
      end else begin
        fill_mask_s = {XLEN{1'b0}};
      end
      o_data = (i_data >> i_amt) | fill_mask_s;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Integer ALU with single-cycle logic/arith ops and a multi-cycle iterative shifter.
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic [XLEN-1:0] o_result,
  output logic            o_done,
  output logic            o_busy
);

  localparam int AW = $clog2(XLEN) + 1;
  localparam logic [AW-1:0] STEP_C = AW'(SHIFT_STEP);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]      state_r;
  logic [XLEN-1:0] shreg_r;
  logic [AW-1:0]   rem_r;
  logic            left_r;
  logic            fill_r;
  logic            word_r;
  logic [XLEN-1:0] result_r;
  logic            done_r;

  op_dec_t         dec_s;
  logic            accept_s;
  logic            word_s;
  logic [AW-1:0]   shamt_s;
  logic [XLEN-1:0] preload_s;
  logic [XLEN-1:0] step_in_s;
  logic [AW-1:0]   rem_src_s;
  logic [AW-1:0]   amt_s;
  logic [AW-1:0]   rem_next_s;
  logic            left_s;
  logic            fill_s;
  logic            word_cur_s;
  logic [XLEN-1:0] step_out_s;
  logic [XLEN-1:0] final_s;
  logic [XLEN-1:0] opa_s;
  logic [XLEN-1:0] opb_s;
  logic [XLEN-1:0] sum_s;
  logic [XLEN-1:0] diff_s;
  logic [XLEN-1:0] alu_s;

  assign dec_s    = decode_op(i_op);
  assign accept_s = i_start && (state_r == ST_IDLE);
  assign o_result = result_r;
  assign o_done   = done_r;
  assign o_busy   = (state_r == ST_SHIFT);

  // Word-mode qualification, shift amount and shifter preload for a new request.
  always_comb begin
    word_s = (XLEN == 64) ? (i_word && dec_s.wordable) : 1'b0;
    if ((XLEN == 64) && !word_s) begin
      shamt_s = AW'(i_op2[5:0]);
    end else begin
      shamt_s = AW'(i_op2[4:0]);
    end
    if (!word_s) begin
      preload_s = i_op1;
    end else if (dec_s.arith) begin
      preload_s = XLEN'($signed(i_op1[31:0]));
    end else begin
      preload_s = XLEN'(i_op1[31:0]);
    end
  end

  // The first step runs from the request itself, later steps from the held registers.
  always_comb begin
    if (state_r == ST_IDLE) begin
      step_in_s  = preload_s;
      rem_src_s  = shamt_s;
      left_s     = dec_s.left;
      fill_s     = dec_s.arith && preload_s[XLEN-1];
      word_cur_s = word_s;
    end else begin
      step_in_s  = shreg_r;
      rem_src_s  = rem_r;
      left_s     = left_r;
      fill_s     = fill_r;
      word_cur_s = word_r;
    end
    amt_s      = (rem_src_s > STEP_C) ? STEP_C : rem_src_s;
    rem_next_s = rem_src_s - amt_s;
    if (word_cur_s) begin
      final_s = XLEN'($signed(step_out_s[31:0]));
    end else begin
      final_s = step_out_s;
    end
  end

  alu_shift_step #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_shift_step (
    .i_data (step_in_s),
    .i_amt  (amt_s),
    .i_left (left_s),
    .i_fill (fill_s),
    .o_data (step_out_s)
  );

  // Single-cycle ops; word-mode add/sub use zero-extended low halves then sign-extend.
  always_comb begin
    opa_s  = word_s ? XLEN'(i_op1[31:0]) : i_op1;
    opb_s  = word_s ? XLEN'(i_op2[31:0]) : i_op2;
    sum_s  = opa_s + opb_s;
    diff_s = opa_s - opb_s;
    case (i_op)
      OP_ADD:  alu_s = word_s ? XLEN'($signed(sum_s[31:0])) : sum_s;
      OP_SUB:  alu_s = word_s ? XLEN'($signed(diff_s[31:0])) : diff_s;
      OP_SLT:  alu_s = XLEN'($signed(i_op1) < $signed(i_op2));
      OP_SLTU: alu_s = XLEN'(i_op1 < i_op2);
      OP_XOR:  alu_s = i_op1 ^ i_op2;
      OP_OR:   alu_s = i_op1 | i_op2;
      OP_AND:  alu_s = i_op1 & i_op2;
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM, shift state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      shreg_r  <= {XLEN{1'b0}};
      rem_r    <= {AW{1'b0}};
      left_r   <= 1'b0;
      fill_r   <= 1'b0;
      word_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (!dec_s.is_shift) begin
              result_r <= alu_s;
              done_r   <= 1'b1;
            end else if (rem_next_s == {AW{1'b0}}) begin
              result_r <= final_s;
              done_r   <= 1'b1;
            end else begin
              state_r <= ST_SHIFT;
              shreg_r <= step_out_s;
              rem_r   <= rem_next_s;
              left_r  <= left_s;
              fill_r  <= fill_s;
              word_r  <= word_s;
            end
          end
        end
        ST_SHIFT: begin
          shreg_r <= step_out_s;
          rem_r   <= rem_next_s;
          if (rem_next_s == {AW{1'b0}}) begin
            state_r  <= ST_IDLE;
            result_r <= final_s;
            done_r   <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed and randomized checks of alu_iter (XLEN=64, SHIFT_STEP=8) against a behavioural model.
module tb_alu_iter;
  import alu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [3:0]  i_op;
  logic        i_word;
  logic [63:0] i_op1;
  logic [63:0] i_op2;
  logic [63:0] o_result;
  logic        o_done;
  logic        o_busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] last_res = 64'd0;

  alu_iter #(.XLEN(64), .SHIFT_STEP(8)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_word   (i_word),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .o_result (o_result),
    .o_done   (o_done),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Result and cycle count straight from the operation definitions.
  function automatic void model(input logic [3:0] op, input bit word, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r, output int n);
    bit w;
    int sh;
    logic [31:0] t32;
    logic signed [31:0] s32;
    logic signed [63:0] s64;
    w  = word && (op == OP_ADD || op == OP_SUB || is_shift(op));
    sh = w ? int'(b[4:0]) : int'(b[5:0]);
    r  = 64'd0;
    case (op)
      OP_ADD:  begin t32 = a[31:0] + b[31:0]; r = w ? {{32{t32[31]}}, t32} : a + b; end
      OP_SUB:  begin t32 = a[31:0] - b[31:0]; r = w ? {{32{t32[31]}}, t32} : a - b; end
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      OP_SLTU: r = (a < b) ? 64'd1 : 64'd0;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLL:  begin t32 = a[31:0] << sh; r = w ? {{32{t32[31]}}, t32} : a << sh; end
      OP_SRL:  begin t32 = a[31:0] >> sh; r = w ? {{32{t32[31]}}, t32} : a >> sh; end
      OP_SRA:  begin
        if (w) begin
          s32 = a[31:0]; s32 = s32 >>> sh; r = {{32{s32[31]}}, s32};
        end else begin
          s64 = a; s64 = s64 >>> sh; r = s64;
        end
      end
      default: r = 64'd0;
    endcase
    n = (is_shift(op) && sh > 0) ? (sh + 7) / 8 : 1;
  endfunction

  // Issue one request (called one time unit after a rising edge) and check it to completion.
  task automatic do_op(input string tag, input logic [3:0] op, input bit word,
                       input logic [63:0] a, input logic [63:0] b, input bit inject);
    logic [63:0] exp;
    int n, lat, busy_cnt;
    model(op, word, a, b, exp, n);
    i_op = op; i_word = word; i_op1 = a; i_op2 = b; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_op1 = {$urandom, $urandom};
    i_op2 = {$urandom, $urandom};
    lat = 1; busy_cnt = 0;
    while (!o_done && lat < 100) begin
      if (o_busy) busy_cnt++;
      check({tag, " held"}, o_result, last_res);
      if (inject && lat == 2) begin
        i_start = 1'b1; i_op = OP_ADD; i_word = 1'b0;
      end else begin
        i_start = 1'b0;
      end
      @(posedge i_clk); #1;
      lat++;
    end
    i_start = 1'b0;
    check({tag, " done"}, 64'(o_done), 64'd1);
    check({tag, " result"}, o_result, exp);
    check({tag, " latency"}, 64'(lat), 64'(n));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(n - 1));
    check({tag, " busy at done"}, 64'(o_busy), 64'd0);
    last_res = exp;
  endtask

  logic [3:0] ops [12] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
                           OP_SRL, OP_SRA, OP_OR, OP_AND, 4'b1001, 4'b1111};

  initial begin
    int dones;
    i_rst_n = 1'b0; i_start = 1'b0; i_op = 4'd0; i_word = 1'b0;
    i_op1 = 64'd0; i_op2 = 64'd0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset result", o_result, 64'd0);
    check("reset done", 64'(o_done), 64'd0);
    check("reset busy", 64'(o_busy), 64'd0);
    #3 i_rst_n = 1'b1;

    // Accepted on the first edge after reset release.
    do_op("add wrap", OP_ADD, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    do_op("sll 63", OP_SLL, 1'b0, 64'd1, 64'd63, 1'b1);
    check("sll 63 value", o_result, 64'h8000_0000_0000_0000);
    @(posedge i_clk); #1;
    check("no queued op", 64'(o_done), 64'd0);
    check("result kept", o_result, 64'h8000_0000_0000_0000);

    do_op("sraw", OP_SRA, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 1'b0);
    check("sraw value", o_result, 64'hFFFF_FFFF_F800_0000);
    do_op("addw", OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 1'b0);
    check("addw value", o_result, 64'hFFFF_FFFF_8000_0000);
    do_op("sra 20", OP_SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd20, 1'b0);
    check("sra 20 value", o_result, 64'hFFFF_F800_0000_0000);
    do_op("sltu b2b", OP_SLTU, 1'b0, 64'd1, 64'd2, 1'b0);
    check("sltu value", o_result, 64'd1);

    // Reset in the middle of a five-step shift.
    i_op = OP_SLL; i_word = 1'b0; i_op1 = 64'd1; i_op2 = 64'd40; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("sll 40 busy", 64'(o_busy), 64'd1);
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    check("mid reset busy", 64'(o_busy), 64'd0);
    check("mid reset done", 64'(o_done), 64'd0);
    check("mid reset result", o_result, 64'd0);
    #3 i_rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge i_clk); #1;
      if (o_done) dones++;
    end
    check("no done after reset", 64'(dones), 64'd0);
    last_res = 64'd0;
    do_op("add after reset", OP_ADD, 1'b0, 64'd1, 64'd1, 1'b0);
    check("add 1+1 value", o_result, 64'd2);
    do_op("illegal op", 4'b1001, 1'b0, 64'hFF, 64'hFF, 1'b0);
    check("illegal value", o_result, 64'd0);
    do_op("sll zero", OP_SLL, 1'b0, 64'h1234, 64'd0, 1'b0);
    do_op("srl 8", OP_SRL, 1'b0, 64'hF000_0000_0000_0000, 64'd8, 1'b0);
    do_op("srlw 9", OP_SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd9, 1'b0);

    for (int k = 0; k < 60; k++) begin
      do_op("random", ops[$urandom_range(0, 11)], 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
